// File: rtl/pt5_unpacker_pkg.sv
// Shared definitions for the PT-5 (five trits per byte) unpacker: trit codes,
// packing constants and the buffer FSM state type.
package pt5_unpacker_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  localparam int         PT5_TRITS     = 5;
  localparam logic [7:0] PT5_MAX_VALID = 8'd242;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef logic [2*PT5_TRITS-1:0] pt5_code_t;

  // Base-3 digit 0/1/2 maps onto the 0/+1/-1 trit codes.
  function automatic logic [1:0] digit_to_trit(input logic [1:0] digit);
    case (digit)
      2'd1:    return TRIT_POS;
      2'd2:    return TRIT_NEG;
      default: return TRIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/pt5_unpacker_if.sv
// Byte-in / trit-vector-out stream bundle. master drives bytes and accepts
// beats; slave is the unpacker.
interface pt5_unpacker_if #(
  parameter int LANES = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [2*LANES-1:0] out_trits;
  logic               out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_trits, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_trits, out_last
  );

endinterface

// File: rtl/pt5_decode.sv
// Combinational PT-5 byte decoder: five base-3 digits (least significant first)
// as 2-bit trit codes; bytes above 242 decode to zeros and flag invalid.
module pt5_decode
  import pt5_unpacker_pkg::*;
(
  input  logic [7:0] byte_i,
  output pt5_code_t  trits_o,
  output logic       invalid_o
);

  logic [7:0] quot;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    trits_o   = '0;
    quot      = byte_i;
    invalid_o = (byte_i > PT5_MAX_VALID);
    for (int k = 0; k < PT5_TRITS; k++) begin
      trits_o[2*k +: 2] = digit_to_trit(2'(quot % 8'd3));
      quot              = quot / 8'd3;
    end
    if (invalid_o) begin
      trits_o = '0;
    end
  end

endmodule

// File: rtl/pt5_unpacker.sv
// PT-5 unpacker: decodes packed bytes into a trit buffer and emits LANES-wide
// trit vectors, zero-padding the final beat of each frame.
module pt5_unpacker
  import pt5_unpacker_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pt5_unpacker_if.slave        bus,
  output logic [15:0]          err_count_o
);

  localparam int                DEPTH   = LANES + PT5_TRITS - 1;
  localparam int                FILL_W  = $clog2(LANES + PT5_TRITS);
  localparam logic [FILL_W-1:0] LANES_F = FILL_W'(LANES);

  state_e                  state_q, state_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [DEPTH-1:0][1:0]   buf_q, buf_d;
  logic [15:0]             err_q, err_d;

  pt5_code_t dec_trits;
  logic      dec_invalid;
  logic      in_fire;
  logic      out_fire;

  pt5_decode u_decode (
    .byte_i    (bus.in_data),
    .trits_o   (dec_trits),
    .invalid_o (dec_invalid)
  );

  // Handshake outputs depend only on registered state.
  assign bus.in_ready  = (state_q == ST_FILL) && (fill_q <= LANES_F - 1'b1);
  assign bus.out_valid = (fill_q >= LANES_F) || ((state_q == ST_DRAIN) && (fill_q != '0));
  assign bus.out_last  = (state_q == ST_DRAIN) && (fill_q <= LANES_F);
  assign err_count_o   = err_q;

  assign in_fire  = bus.in_valid  && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    bus.out_trits = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.out_trits[2*i +: 2] = (FILL_W'(i) < fill_q) ? buf_q[i] : TRIT_ZERO;
    end
  end

  // The fill ranges for accepting and emitting are disjoint, so at most one fires.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    err_d   = err_q;
    if (in_fire) begin
      for (int k = 0; k < PT5_TRITS; k++) begin
        buf_d[fill_q + FILL_W'(k)] = dec_trits[2*k +: 2];
      end
      fill_d = fill_q + FILL_W'(PT5_TRITS);
      if (dec_invalid && (err_q != 16'hFFFF)) begin
        err_d = err_q + 16'd1;
      end
      if (bus.in_last) begin
        state_d = ST_DRAIN;
      end
    end else if (out_fire) begin
      for (int i = 0; i < DEPTH - LANES; i++) begin
        buf_d[i] = buf_q[i + LANES];
      end
      for (int i = DEPTH - LANES; i < DEPTH; i++) begin
        buf_d[i] = TRIT_ZERO;
      end
      fill_d = (fill_q > LANES_F) ? (fill_q - LANES_F) : '0;
      if ((state_q == ST_DRAIN) && (fill_q <= LANES_F)) begin
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      // NOTE: the trit buffer is reset too, so a frame cut short by reset can
      // never leak stale trits into a later beat.
      buf_q   <= '0;
      err_q   <= '0;
    end else begin
      // NOTE: non-blocking '<=' for all registers, so every flop samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pt5_unpacker.sv
// Directed bench for pt5_unpacker: hand-computed beats for valid, boundary,
// invalid, stalled and reset-in-drain sequences.
module tb_pt5_unpacker;

  localparam int LANES = 16;

  logic        clk;
  logic        reset;
  logic [15:0] err_count;
  logic        stable;

  int n_checks = 0;
  int n_pass   = 0;

  pt5_unpacker_if #(.LANES(LANES)) bus ();

  pt5_unpacker #(.LANES(LANES)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .err_count_o (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Entered and left on a negedge; waits (bounded) for in_ready, then offers one byte.
  task automatic send_byte(input logic [7:0] data, input logic last);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take_beat(input string tag, input logic [31:0] exp_trits, input logic exp_last);
    int t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_trits"}, bus.out_trits, exp_trits);
    check({tag, "_last"},  bus.out_last,  exp_last);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_trits", bus.out_trits, 0);
    check("rst_out_last",  bus.out_last,  0);
    check("rst_err",       err_count,     0);
    reset = 1'b0;
    @(negedge clk);

    // Four all-ones bytes: one full beat, four trits left over.
    repeat (3) send_byte(8'd121, 1'b0);
    check("partial_no_valid", bus.out_valid, 0);
    send_byte(8'd121, 1'b0);
    check("latency_valid", bus.out_valid, 1);
    check("full_in_ready", bus.in_ready, 0);
    take_beat("ones", 32'h5555_5555, 1'b0);
    check("rem_in_ready", bus.in_ready, 1);
    check("rem_no_valid", bus.out_valid, 0);
    send_byte(8'd121, 1'b1);
    take_beat("ones_tail", 32'h0001_5555, 1'b1);
    check("tail_in_ready", bus.in_ready, 1);
    check("tail_no_valid", bus.out_valid, 0);

    // Single-byte frames: padding and digit ordering (146 = digits 2,0,1,2,1).
    send_byte(8'd121, 1'b1);
    take_beat("single", 32'h0000_0155, 1'b1);
    check("single_in_ready", bus.in_ready, 1);
    send_byte(8'd146, 1'b1);
    take_beat("order", 32'h0000_0192, 1'b1);

    // Largest valid byte, then a zero byte closing the frame.
    repeat (4) send_byte(8'd242, 1'b0);
    take_beat("twos", 32'hAAAA_AAAA, 1'b0);
    send_byte(8'd0, 1'b1);
    take_beat("twos_tail", 32'h0000_00AA, 1'b1);

    // Invalid bytes decode to zeros and are counted.
    send_byte(8'd243, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'd121, 1'b1);
    take_beat("invalid", 32'h1550_0000, 1'b1);
    check("err_two", err_count, 16'd2);

    // Downstream stall with a byte pending upstream.
    repeat (4) send_byte(8'd121, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd146;
    bus.in_last  = 1'b1;
    stable       = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_trits !== 32'h5555_5555 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("stall_resume_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take_beat("stall_tail", 32'h0001_9255, 1'b1);
    check("stall_err", err_count, 16'd2);

    // Reset while draining with four trits buffered.
    repeat (3) send_byte(8'd121, 1'b0);
    send_byte(8'd121, 1'b1);
    take_beat("drain_head", 32'h5555_5555, 1'b0);
    check("drain_rem_valid", bus.out_valid, 1);
    check("drain_rem_last",  bus.out_last,  1);
    check("drain_in_ready",  bus.in_ready,  0);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", bus.out_valid, 0);
    check("rst2_in_ready",  bus.in_ready,  1);
    check("rst2_err",       err_count,     0);
    check("rst2_out_trits", bus.out_trits, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", bus.out_valid, 0);
    send_byte(8'd146, 1'b1);
    take_beat("post_rst", 32'h0000_0192, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
